stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_if.sv | 28 ++
 rtl/stage_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and its pipeline stages.
// Carries per-stage ready/start/reset/valid bits, global jump/stall and the perf counters.
interface stage_sequencer_if #(
    parameter int unsigned STAGES      = 5,
    parameter int unsigned COUNT_WIDTH = 32
);
    logic [STAGES-1:0]      readyBitsIn;
    logic                   jumpLatchIn;
    logic                   stallIn;
    logic [STAGES-1:0]      startBitsOut;
    logic [STAGES-1:0]      resetBitsOut;
    logic [STAGES-1:0]      validBitsOut;
    logic                   retireOut;
    logic [COUNT_WIDTH-1:0] retiredCountOut;
    logic [COUNT_WIDTH-1:0] flushCountOut;

    modport master (
        output readyBitsIn, jumpLatchIn, stallIn,
        input  startBitsOut, resetBitsOut, validBitsOut, retireOut,
        input  retiredCountOut, flushCountOut
    );

    modport slave (
        input  readyBitsIn, jumpLatchIn, stallIn,
        output startBitsOut, resetBitsOut, validBitsOut, retireOut,
        output retiredCountOut, flushCountOut
    );
endinterface

// File: rtl/stage_sequencer.sv
// Sequences items through a linear pipeline of STAGES stages with jump flush and stall.
// Define STAGE_SEQUENCER_PERF_EN to build the retired/flush performance counters.
module stage_sequencer #(
    parameter int unsigned STAGES      = 5,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input logic              clockIn,
    input logic              resetIn,
    stage_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StBusy, StDone} stage_state_e;

    stage_state_e      r_state   [STAGES];
    stage_state_e      w_state_d [STAGES];
    logic [STAGES-1:0] w_leave;
    logic [STAGES-1:0] w_accept;
    logic [STAGES-1:0] w_start;
    logic [STAGES-1:0] w_reset;
    logic [STAGES-1:0] w_valid;
    logic              w_move_ok;
    logic              w_retire;
    int unsigned       w_idx;

    always_comb begin
        w_move_ok = !resetIn && !bus.stallIn && !bus.jumpLatchIn;
        w_leave   = '0;
        w_accept  = '0;
        w_start   = '0;
        w_valid   = '0;
        w_idx     = 0;

        // Acceptance ripples from the last stage back to stage 0 within the cycle.
        // A jump does not block the last stage from retiring.
        w_leave[STAGES-1]  = (r_state[STAGES-1] == StDone) && !resetIn && !bus.stallIn;
        w_accept[STAGES-1] = (r_state[STAGES-1] == StIdle) || w_leave[STAGES-1];
        for (int unsigned j = 0; j < STAGES - 1; j++) begin
            w_idx           = STAGES - 2 - j;
            w_leave[w_idx]  = (r_state[w_idx] == StDone) && w_accept[w_idx+1] && w_move_ok;
            w_accept[w_idx] = (r_state[w_idx] == StIdle) || w_leave[w_idx];
        end

        w_start[0] = w_accept[0] && w_move_ok;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_start[i] = w_leave[i-1];
        end
        w_retire = w_leave[STAGES-1];

        if (resetIn) begin
            w_reset = '1;
        end else if (bus.jumpLatchIn) begin
            w_reset = {1'b0, {(STAGES-1){1'b1}}};
        end else begin
            w_reset = '0;
        end

        for (int unsigned i = 0; i < STAGES; i++) begin
            w_valid[i]   = (r_state[i] != StIdle);
            w_state_d[i] = r_state[i];
            case (r_state[i])
                StArmed: w_state_d[i] = StBusy;
                StBusy:  if (bus.readyBitsIn[i]) w_state_d[i] = StDone;
                default: w_state_d[i] = r_state[i];
            endcase
            if (w_leave[i]) w_state_d[i] = StIdle;
            if (w_start[i]) w_state_d[i] = StArmed;
            if (bus.jumpLatchIn && (i < STAGES - 1)) w_state_d[i] = StIdle;
        end
    end

    always_ff @(posedge clockIn) begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (resetIn) begin
                r_state[i] <= StIdle;
            end else begin
                r_state[i] <= w_state_d[i];
            end
        end
    end

    assign bus.startBitsOut = w_start;
    assign bus.resetBitsOut = w_reset;
    assign bus.validBitsOut = w_valid;
    assign bus.retireOut    = w_retire;

`ifdef STAGE_SEQUENCER_PERF_EN
    logic [COUNT_WIDTH-1:0] r_retired_cnt;
    logic [COUNT_WIDTH-1:0] r_flush_cnt;

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_retired_cnt <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_retire)        r_retired_cnt <= r_retired_cnt + COUNT_WIDTH'(1);
            if (bus.jumpLatchIn) r_flush_cnt   <= r_flush_cnt + COUNT_WIDTH'(1);
        end
    end

    assign bus.retiredCountOut = r_retired_cnt;
    assign bus.flushCountOut   = r_flush_cnt;
`else
    assign bus.retiredCountOut = '0;
    assign bus.flushCountOut   = '0;
`endif
endmodule
